// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - md_unit operation request and HI/LO result bundle
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output md_op, src_a, src_b, cancel,
        input  busy, hi, lo, mf_data
    );

    modport slave (
        input  md_op, src_a, src_b, cancel,
        output busy, hi, lo, mf_data
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset_n,
    md_unit_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             start;
    logic             start_mult;
    logic             is_mult;
    logic             neg_a, neg_b;
    logic [WIDTH:0]   mag_a, mag_b, div_b, quo_m, rem_m;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             res_we;

    assign start      = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);
    assign start_mult = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // next state: accept mult/div in IDLE, leave RUN on last count or cancel
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!bus.cancel && start)             state_d = S_RUN;
            S_RUN:  if (bus.cancel || cnt_q == 8'd1)      state_d = S_IDLE;
        endcase
    end

    // result from latched operands; signed divide works on magnitudes one bit wider
    // so that the most negative dividend never overflows
    always_comb begin
        is_mult = (op_q == OP_MULT) || (op_q == OP_MULTU);
        neg_a   = (op_q == OP_DIV) && a_q[WIDTH-1];
        neg_b   = (op_q == OP_DIV) && b_q[WIDTH-1];
        mag_a   = neg_a ? -{a_q[WIDTH-1], a_q} : {1'b0, a_q};
        mag_b   = neg_b ? -{b_q[WIDTH-1], b_q} : {1'b0, b_q};
        div_b   = (mag_b == '0) ? {{WIDTH{1'b0}}, 1'b1} : mag_b;
        quo_m   = mag_a / div_b;
        rem_m   = mag_a % div_b;
        if (op_q == OP_MULT)
            prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        else
            prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        if (is_mult) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
            res_we = 1'b1;
        end else begin
            res_lo = WIDTH'((neg_a ^ neg_b) ? -quo_m : quo_m);
            res_hi = WIDTH'(neg_a ? -rem_m : rem_m);
            res_we = (b_q != '0);
        end
    end

    // counter, operand latches and HI/LO writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (state_q == S_IDLE) begin
            if (!bus.cancel) begin
                if (start) begin
                    cnt_q <= start_mult ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
                    op_q  <= bus.md_op;
                    a_q   <= bus.src_a;
                    b_q   <= bus.src_b;
                end else if (bus.md_op == OP_MTHI) begin
                    hi_q <= bus.src_a;
                end else if (bus.md_op == OP_MTLO) begin
                    lo_q <= bus.src_a;
                end
            end
        end else if (bus.cancel) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1 && res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    // outputs: busy from state, combinational move-from read port
    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.hi   = hi_q;
        bus.lo   = lo_q;
        case (bus.md_op)
            OP_MFHI: bus.mf_data = hi_q;
            OP_MFLO: bus.mf_data = lo_q;
            default: bus.mf_data = '0;
        endcase
    end
endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit with a behavioural reference model
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(32)) bus ();
    md_unit_if #(.WIDTH(16)) bus16 ();

    md_unit #(.WIDTH(32), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave));
    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus16.slave));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_hi   = '0;
    logic [31:0] ref_lo   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    endtask

    // reference: plain 64-bit arithmetic on the architectural values
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = ref_hi;
        l  = ref_lo;
        case (op)
            4'd1: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            4'd2: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            4'd4: if (b != 0) begin l = a / b; h = a % b; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle(input bit garble);
        int k;
        k = 0;
        while (bus.busy && k < 300) begin
            if (garble) begin
                bus.md_op = 4'($urandom_range(0, 15));
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.md_op = 4'd0;
        check("idle_after_op", 32'(bus.busy), 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit garble);
        exp_t        e;
        logic [31:0] h, l;
        ref_op(op, a, b, h, l);
        e.hi     = h;
        e.lo     = l;
        e.cycles = (op <= 4'd2) ? MULT_N : DIV_N;
        exp_q.push_back(e);
        ref_hi    = h;
        ref_lo    = l;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        check("busy_in_accept_cycle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.md_op = 4'd0;
        wait_idle(garble);
    endtask

    task automatic mt_mf(input bit sel_hi, input logic [31:0] v, input bit cancel_it);
        bus.md_op  = sel_hi ? 4'd7 : 4'd8;
        bus.src_a  = v;
        bus.cancel = cancel_it;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        if (!cancel_it) begin
            if (sel_hi) ref_hi = v;
            else        ref_lo = v;
        end
        check("mt_busy", 32'(bus.busy), 32'd0);
        bus.md_op = sel_hi ? 4'd5 : 4'd6;
        #1 check(sel_hi ? "mfhi_data" : "mflo_data", bus.mf_data, sel_hi ? ref_hi : ref_lo);
        @(posedge clk); #1;
        bus.md_op = 4'd0;
        #1 check("mf_idle_zero", bus.mf_data, 32'd0);
    endtask

    task automatic cancel_at(input logic [3:0] op, input int k, input bit present);
        exp_t e;
        e.hi     = ref_hi;
        e.lo     = ref_lo;
        e.cycles = k;
        exp_q.push_back(e);
        bus.md_op = op;
        bus.src_a = $urandom | 32'h10;
        bus.src_b = $urandom | 32'h3;
        @(posedge clk); #1;
        for (int c = 1; c < k; c++) begin
            bus.md_op = (present && c >= 2) ? 4'd3 : 4'd0;
            @(posedge clk); #1;
        end
        bus.md_op  = present ? 4'd3 : 4'd0;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        bus.md_op  = 4'd0;
        check("cancel_busy_low", 32'(bus.busy), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("cancel_no_accept", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic reserved_op();
        bus.md_op = 4'($urandom_range(9, 15));
        bus.src_a = $urandom;
        bus.src_b = $urandom | 32'h1;
        #1 check("reserved_mf", bus.mf_data, 32'd0);
        @(posedge clk); #1;
        bus.md_op = 4'd0;
        check("reserved_busy", 32'(bus.busy), 32'd0);
        check("reserved_hi", bus.hi, ref_hi);
        check("reserved_lo", bus.lo, ref_lo);
    endtask

    // monitor: each busy fall completes one queued operation
    initial begin : monitor
        exp_t e;
        int   cnt;
        bit   prev;
        cnt  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                cnt++;
            end else if (prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("done_hi", bus.hi, e.hi);
                    check("done_lo", bus.lo, e.lo);
                    if (e.cycles >= 0) check("busy_len", 32'(cnt), 32'(e.cycles));
                end
                cnt = 0;
            end
            prev = bus.busy;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int          sel, k;
        logic [3:0]  op;
        exp_t        e;
        reset_n      = 1'b0;
        bus.md_op    = '0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
        bus16.md_op  = '0; bus16.src_a = '0; bus16.src_b = '0; bus16.cancel = 1'b0;
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy16", 32'(bus16.busy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        mt_mf(1'b1, 32'h1234_5678, 1'b0);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        mt_mf(1'b0, 32'hCAFE_0001, 1'b1);

        cancel_at(4'd1, 3, 1'b1);
        cancel_at(4'd1, MULT_N, 1'b0);
        cancel_at(4'd3, 1, 1'b0);
        cancel_at(4'd3, DIV_N, 1'b0);

        bus.md_op = 4'd1; bus.src_a = 32'h55; bus.src_b = 32'h77; bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.md_op = 4'd0; bus.cancel = 1'b0;
        check("idle_cancel_no_accept", 32'(bus.busy), 32'd0);

        mt_mf(1'b1, 32'hA5A5_A5A5, 1'b0);
        e.hi = 32'd0; e.lo = 32'd0; e.cycles = -1;
        exp_q.push_back(e);
        bus.md_op = 4'd3; bus.src_a = $urandom; bus.src_b = 32'd5;
        @(posedge clk); #1;
        bus.md_op = 4'd0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check("midrun_rst_hi", bus.hi, 32'd0);
        check("midrun_rst_lo", bus.lo, 32'd0);
        ref_hi = '0;
        ref_lo = '0;
        @(negedge clk); #2;
        reset_n = 1'b1;
        issue(4'd1, $urandom, $urandom, 1'b0);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            op  = 4'($urandom_range(1, 4));
            if (sel <= 5) begin
                issue(op, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
            end else if (sel <= 7) begin
                mt_mf(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
            end else if (sel == 8) begin
                reserved_op();
            end else begin
                k = (op <= 4'd2) ? $urandom_range(1, MULT_N) : $urandom_range(1, DIV_N);
                cancel_at(op, k, 1'b0);
            end
        end

        bus16.md_op = 4'd1; bus16.src_a = 16'h8000; bus16.src_b = 16'h8000;
        #1 check("w16_busy_pre", 32'(bus16.busy), 32'd0);
        @(posedge clk); #1;
        bus16.md_op = 4'd0;
        check("w16_busy_run", 32'(bus16.busy), 32'd1);
        @(posedge clk); #1;
        check("w16_busy_done", 32'(bus16.busy), 32'd0);
        check("w16_mult_hi", 32'(bus16.hi), 32'h4000);
        check("w16_mult_lo", 32'(bus16.lo), 32'h0000);
        bus16.md_op = 4'd3; bus16.src_a = 16'h8000; bus16.src_b = 16'hFFFF;
        @(posedge clk); #1;
        bus16.md_op = 4'd0;
        check("w16_div_busy", 32'(bus16.busy), 32'd1);
        @(posedge clk); #1;
        check("w16_div_hi", 32'(bus16.hi), 32'h0000);
        check("w16_div_lo", 32'(bus16.lo), 32'h8000);

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
